v_issue_sched: RTL and testbench

//  Parametrised successor to the combinational vector scheduler: issue control for all V-register instructions (140-177).

---
 rtl/v_sched_pkg.sv | 80 ++++++++
 rtl/v_sb_counter.sv | 36 +++
 rtl/v_issue_sched.sv | 147 ++++++++++++++
 tb/tb_v_issue_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_sched_pkg.sv
// Shared types, FU codes and pipeline delays for the vector issue scheduler.
// Also holds the instruction decode table for the 140-177 vector group.
package v_sched_pkg;

  typedef enum logic [2:0] {
    FU_VLOG   = 3'd0,
    FU_VSHIFT = 3'd1,
    FU_VADD   = 3'd2,
    FU_FPMUL  = 3'd3,
    FU_FPADD  = 3'd4,
    FU_FPRA   = 3'd5,
    FU_VPOP   = 3'd6,
    FU_MEM    = 3'd7
  } fu_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } pst_e;

  localparam logic [3:0] D_VLOG    = 4'd2;
  localparam logic [3:0] D_VSHIFT  = 4'd4;
  localparam logic [3:0] D_VADD    = 4'd3;
  localparam logic [3:0] D_FPMUL   = 4'd7;
  localparam logic [3:0] D_FPADD   = 4'd6;
  localparam logic [3:0] D_FPRECIP = 4'd14;
  localparam logic [3:0] D_VPOP    = 4'd5;
  localparam logic [3:0] D_MEM_RD  = 4'd9;
  localparam logic [3:0] D_MEM_WR  = 4'd11;

  typedef struct packed {
    logic       v_type;
    fu_e        fu;
    logic [3:0] delay;
    logic       vi_en;
    logic       vj_en;
    logic       vk_en;
    logic       a_chk;
  } dec_t;

  // op is cip[15:9]; op[0] doubles as the Vj-vs-Sj select of the 140-147 group.
  function automatic dec_t v_decode(input logic [6:0] op, input logic [2:0] k);
    dec_t d;
    d = '0;
    if (op >= 7'o140 && op <= 7'o147) begin
      d.v_type = 1'b1; d.fu = FU_VLOG; d.delay = D_VLOG;
      d.vi_en = 1'b1; d.vj_en = op[0]; d.vk_en = 1'b1;
    end else if (op >= 7'o150 && op <= 7'o153) begin
      d.v_type = 1'b1; d.fu = FU_VSHIFT; d.delay = D_VSHIFT;
      d.vi_en = 1'b1; d.vj_en = 1'b1;
    end else if (op >= 7'o154 && op <= 7'o157) begin
      d.v_type = 1'b1; d.fu = FU_VADD; d.delay = D_VADD;
      d.vi_en = 1'b1; d.vj_en = 1'b1; d.vk_en = 1'b1;
    end else if (op >= 7'o160 && op <= 7'o167) begin
      d.v_type = 1'b1; d.fu = FU_FPMUL; d.delay = D_FPMUL;
      d.vi_en = 1'b1; d.vj_en = 1'b1; d.vk_en = 1'b1;
    end else if (op >= 7'o170 && op <= 7'o173) begin
      d.v_type = 1'b1; d.fu = FU_FPADD; d.delay = D_FPADD;
      d.vi_en = 1'b1; d.vj_en = 1'b1; d.vk_en = 1'b1;
    end else if (op == 7'o174) begin
      if (k == 3'd0) begin
        d.v_type = 1'b1; d.fu = FU_FPRA; d.delay = D_FPRECIP;
        d.vi_en = 1'b1; d.vj_en = 1'b1;
      end else if (k == 3'd1 || k == 3'd2) begin
        d.v_type = 1'b1; d.fu = FU_VPOP; d.delay = D_VPOP;
        d.vi_en = 1'b1; d.vj_en = 1'b1;
      end
    end else if (op == 7'o175) begin
      d.v_type = 1'b1; d.fu = FU_VLOG; d.delay = D_VLOG; d.vj_en = 1'b1;
    end else if (op == 7'o176) begin
      d.v_type = 1'b1; d.fu = FU_MEM; d.delay = D_MEM_WR;
      d.vi_en = 1'b1; d.a_chk = 1'b1;
    end else if (op == 7'o177) begin
      d.v_type = 1'b1; d.fu = FU_MEM; d.delay = D_MEM_RD;
      d.vj_en = 1'b1; d.a_chk = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/v_sb_counter.sv
// One scoreboard countdown: load wins over decrement, saturates at zero.
// o_win flags the chaining window measured against the VL latched at load.
module v_sb_counter #(
  parameter int CNT_W     = 8,
  parameter int CHAIN_WIN = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_vl,
  output logic             o_zero,
  output logic             o_win
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_vl;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_vl  <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_vl  <= i_vl;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);
  // vl_q - CHAIN_WIN < cnt <= vl_q, rearranged so nothing underflows
  assign o_win  = (r_cnt <= r_vl) &&
                  (({1'b0, r_cnt} + (CNT_W+1)'(CHAIN_WIN)) > {1'b0, r_vl});

endmodule

// File: rtl/v_issue_sched.sv
// Issue control for V-register instructions: decode, per-register/per-FU
// scoreboard with chaining windows, and a short-VL postpone FSM.
module v_issue_sched
  import v_sched_pkg::*;
#(
  parameter int LOGDEPTH  = 6,
  parameter int NVFU      = 8,
  parameter int SHORT_VL  = 1,
  parameter int POSTPONE  = 2,
  parameter int CHAIN_WIN = 1,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic [15:0]         i_cip,
  input  logic                i_cip_vld,
  input  logic [7:0]          i_a_res_mask,
  input  logic [LOGDEPTH:0]   i_vl,
  input  logic [7:0]          i_vreg_busy,
  input  logic [7:0]          i_vreg_chain_n,
  input  logic [NVFU-1:0]     i_vfu_busy,
  output logic                o_v_issue,
  output logic [7:0]          o_vwrite_start,
  output logic [7:0]          o_vread_start,
  output logic [NVFU-1:0]     o_vfu_start,
  output logic [2:0]          o_fu,
  output logic [3:0]          o_fu_delay,
  output logic                o_hold,
  output logic [7:0]          o_sb_busy
);

  localparam int VLW    = LOGDEPTH + 1;
  localparam int PCNT_W = (POSTPONE < 2) ? 1 : $clog2(POSTPONE + 1);

  dec_t             w_dec;
  logic [2:0]       w_i, w_j, w_k;
  logic [VLW-1:0]   w_vl;
  logic [CNT_W-1:0] w_wr_val, w_vl_c;
  logic [7:0]       w_wr_zero, w_wr_win, w_rd_zero, w_rd_win, w_wr_ld, w_rd_ld;
  logic [NVFU-1:0]  w_fu_zero, w_fu_win, w_fu_ld;
  logic             w_vi_ok, w_vj_ok, w_vk_ok, w_fu_ok, w_a_conflict, w_ready;
  logic             w_issue, w_issue_g, w_unused;
  pst_e             r_state, w_state_nx;
  logic [PCNT_W-1:0] r_pcnt, w_pcnt_nx;
  logic [15:0]      r_cip, w_cip_nx;

  assign w_dec  = v_decode(i_cip[15:9], i_cip[2:0]);
  assign w_i    = i_cip[8:6];
  assign w_j    = i_cip[5:3];
  assign w_k    = i_cip[2:0];
  assign w_vl   = (i_vl == '0) ? {1'b1, {LOGDEPTH{1'b0}}} : i_vl;
  assign w_vl_c = CNT_W'(w_vl);
  assign w_wr_val = CNT_W'(w_dec.delay) + w_vl_c + CNT_W'(1);

  assign w_vi_ok = !w_dec.vi_en ||
                   (!i_vreg_busy[w_i] && w_wr_zero[w_i] && w_rd_zero[w_i]);
  assign w_vj_ok = !w_dec.vj_en ||
                   ((!i_vreg_busy[w_j] || !i_vreg_chain_n[w_j]) &&
                    (w_wr_zero[w_j] || w_wr_win[w_j]));
  assign w_vk_ok = !w_dec.vk_en ||
                   ((!i_vreg_busy[w_k] || !i_vreg_chain_n[w_k]) &&
                    (w_wr_zero[w_k] || w_wr_win[w_k]));
  assign w_fu_ok = !i_vfu_busy[w_dec.fu] && w_fu_zero[w_dec.fu];
  assign w_a_conflict = w_dec.a_chk && (i_a_res_mask[0] || i_a_res_mask[w_k]);
  assign w_ready = i_cip_vld && w_dec.v_type && w_vi_ok && w_vj_ok && w_vk_ok &&
                   w_fu_ok && !w_a_conflict;

  // i_cip_vld has no ready: the parcel is accepted exactly on the o_v_issue
  // cycle and decode must hold it (o_hold) until then; an async reset
  // forces every output low.
  assign w_issue_g = w_issue && i_rst_n;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_cip   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pcnt  <= w_pcnt_nx;
      r_cip   <= w_cip_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pcnt_nx  = r_pcnt;
    w_cip_nx   = r_cip;
    w_issue    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ready) begin
          if (w_vl <= VLW'(SHORT_VL)) begin
            w_state_nx = S_WAIT;
            w_pcnt_nx  = PCNT_W'(POSTPONE);
            w_cip_nx   = i_cip;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!i_cip_vld || (i_cip != r_cip)) begin
          w_state_nx = S_IDLE;
        end else if (r_pcnt == PCNT_W'(1)) begin
          if (w_ready) begin
            w_issue    = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_pcnt_nx = r_pcnt - 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < 8; g++) begin : g_vreg
    assign w_wr_ld[g] = w_issue_g && w_dec.vi_en && (w_i == 3'(g));
    assign w_rd_ld[g] = w_issue_g && ((w_dec.vj_en && (w_j == 3'(g))) ||
                                      (w_dec.vk_en && (w_k == 3'(g))));
    v_sb_counter #(.CNT_W(CNT_W), .CHAIN_WIN(CHAIN_WIN)) u_wr (
      .clk(clk), .i_rst_n(i_rst_n), .i_load(w_wr_ld[g]), .i_load_val(w_wr_val),
      .i_vl(w_vl_c), .o_zero(w_wr_zero[g]), .o_win(w_wr_win[g]));
    v_sb_counter #(.CNT_W(CNT_W), .CHAIN_WIN(CHAIN_WIN)) u_rd (
      .clk(clk), .i_rst_n(i_rst_n), .i_load(w_rd_ld[g]), .i_load_val(w_vl_c),
      .i_vl('0), .o_zero(w_rd_zero[g]), .o_win(w_rd_win[g]));
  end

  for (genvar g = 0; g < NVFU; g++) begin : g_fu
    assign w_fu_ld[g] = w_issue_g && (int'(w_dec.fu) == g);
    v_sb_counter #(.CNT_W(CNT_W), .CHAIN_WIN(CHAIN_WIN)) u_fu (
      .clk(clk), .i_rst_n(i_rst_n), .i_load(w_fu_ld[g]), .i_load_val(w_vl_c),
      .i_vl('0), .o_zero(w_fu_zero[g]), .o_win(w_fu_win[g]));
  end

  assign w_unused       = ^{w_rd_win, w_fu_win};
  assign o_v_issue      = w_issue_g;
  assign o_vwrite_start = w_wr_ld;
  assign o_vread_start  = w_rd_ld;
  assign o_vfu_start    = w_fu_ld;
  assign o_fu           = i_rst_n ? 3'(w_dec.fu) : 3'd0;
  assign o_fu_delay     = i_rst_n ? w_dec.delay : 4'd0;
  assign o_hold         = i_rst_n && i_cip_vld && w_dec.v_type && !w_issue_g;
  assign o_sb_busy      = ~w_wr_zero;

endmodule

// File: tb/tb_v_issue_sched.sv
// Directed bench for v_issue_sched: reset, same-cycle issue, postpone,
// chaining, A-reservation conflicts, WAR hold and reload-on-zero.
module tb_v_issue_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cip;
  logic        cip_vld;
  logic [7:0]  a_res_mask;
  logic [6:0]  vl;
  logic [7:0]  vreg_busy, chain_n;
  logic [7:0]  vfu_busy;
  logic        o_v_issue, o_hold;
  logic [7:0]  o_vwrite_start, o_vread_start, o_vfu_start, o_sb_busy;
  logic [2:0]  o_fu;
  logic [3:0]  o_fu_delay;

  int n_vec = 0;
  int n_err = 0;
  int holds;
  logic got;

  always #5 clk = ~clk;

  v_issue_sched dut (
    .clk(clk), .i_rst_n(rst_n), .i_cip(cip), .i_cip_vld(cip_vld),
    .i_a_res_mask(a_res_mask), .i_vl(vl), .i_vreg_busy(vreg_busy),
    .i_vreg_chain_n(chain_n), .i_vfu_busy(vfu_busy), .o_v_issue(o_v_issue),
    .o_vwrite_start(o_vwrite_start), .o_vread_start(o_vread_start),
    .o_vfu_start(o_vfu_start), .o_fu(o_fu), .o_fu_delay(o_fu_delay),
    .o_hold(o_hold), .o_sb_busy(o_sb_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic iss, input logic hold,
                           input logic [7:0] vw, input logic [7:0] vr, input logic [7:0] vf);
    chk({tag, ".issue"}, 32'(o_v_issue), 32'(iss));
    chk({tag, ".hold"}, 32'(o_hold), 32'(hold));
    chk({tag, ".vwrite"}, 32'(o_vwrite_start), 32'(vw));
    chk({tag, ".vread"}, 32'(o_vread_start), 32'(vr));
    chk({tag, ".vfu"}, 32'(o_vfu_start), 32'(vf));
  endtask

  task automatic check_fu(input string tag, input logic [2:0] fu, input logic [3:0] dly);
    chk({tag, ".fu"}, 32'(o_fu), 32'(fu));
    chk({tag, ".delay"}, 32'(o_fu_delay), 32'(dly));
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cip_vld = 1'b0; cip = '0; a_res_mask = '0; vl = 7'd8;
    vreg_busy = '0; chain_n = '0; vfu_busy = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Counts hold cycles until issue; leaves time at the issuing negedge.
  task automatic wait_issue(input int max_cyc, output int nh, output logic ok);
    nh = 0;
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (o_v_issue) begin
        ok = 1'b1;
        break;
      end
      if (o_hold) nh++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: reset state, then reset in the middle of a 20-cycle write countdown
    do_reset();
    smp();
    check_out("rst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("rst.sb_busy", 32'(o_sb_busy), 32'h0);
    adv();
    vl = 7'd15; cip = 16'o150312; cip_vld = 1'b1;
    smp();
    check_out("t1.shift", 1'b1, 1'b0, 8'h08, 8'h02, 8'h02);
    check_fu("t1.shift", 3'd1, 4'd4);
    adv();
    smp();
    check_out("t1.held", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    chk("t1.sb_busy", 32'(o_sb_busy), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t1.inrst", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("t1.inrst.sb_busy", 32'(o_sb_busy), 32'h0);
    check_fu("t1.inrst", 3'd0, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp();
    check_out("t1.after", 1'b1, 1'b0, 8'h08, 8'h02, 8'h02);
    adv();

    // 2: VL=64 FP multiply issues at once; next multiply waits on the FU
    do_reset();
    vl = 7'd0; cip = 16'o160123; cip_vld = 1'b1;
    smp();
    check_out("t2.mul", 1'b1, 1'b0, 8'h02, 8'h0C, 8'h08);
    check_fu("t2.mul", 3'd3, 4'd7);
    adv();
    cip = 16'o160435;
    wait_issue(100, holds, got);
    chk("t2.got", 32'(got), 32'h1);
    chk("t2.holds", 32'(holds), 32'd64);
    check_out("t2.mul2", 1'b1, 1'b0, 8'h10, 8'h28, 8'h08);
    adv();

    // 3: short VL postpones two cycles; dropping valid in WAIT restarts it
    do_reset();
    vl = 7'd1; cip = 16'o140123; cip_vld = 1'b1;
    smp();
    check_out("t3.c0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    smp();
    check_out("t3.c1", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    smp();
    check_out("t3.c2", 1'b1, 1'b0, 8'h02, 8'h08, 8'h01);
    adv();
    cip_vld = 1'b0;
    adv();
    cip = 16'o140456; cip_vld = 1'b1;
    smp();
    check_out("t3.w0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    cip_vld = 1'b0;
    smp();
    check_out("t3.drop", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    adv();
    cip_vld = 1'b1;
    smp();
    check_out("t3.re0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    smp();
    check_out("t3.re1", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    smp();
    check_out("t3.re2", 1'b1, 1'b0, 8'h10, 8'h40, 8'h01);
    adv();

    // 4a: chained read of V1 issues exactly in its window (3 holds)
    do_reset();
    vl = 7'd8; cip = 16'o140123; cip_vld = 1'b1;
    smp();
    check_out("t4.wr", 1'b1, 1'b0, 8'h02, 8'h08, 8'h01);
    adv();
    cip = 16'o154213;
    wait_issue(30, holds, got);
    chk("t4a.got", 32'(got), 32'h1);
    chk("t4a.holds", 32'(holds), 32'd3);
    check_out("t4a.add", 1'b1, 1'b0, 8'h04, 8'h0A, 8'h04);
    check_fu("t4a.add", 3'd2, 4'd3);
    adv();

    // 4b: window missed, read waits until the write counter drains
    do_reset();
    vl = 7'd8; cip = 16'o140123; cip_vld = 1'b1;
    smp();
    adv();
    cip_vld = 1'b0;
    repeat (4) adv();
    cip = 16'o154213; cip_vld = 1'b1;
    wait_issue(30, holds, got);
    chk("t4b.got", 32'(got), 32'h1);
    chk("t4b.holds", 32'(holds), 32'd7);
    adv();

    // external busy / chain-not-possible and FU busy
    do_reset();
    vl = 7'd8; vreg_busy = 8'h08; chain_n = 8'h08; cip = 16'o154213; cip_vld = 1'b1;
    smp();
    check_out("ext.chain_n", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    chain_n = 8'h00;
    smp();
    check_out("ext.chain_ok", 1'b1, 1'b0, 8'h04, 8'h0A, 8'h04);
    adv();
    vreg_busy = 8'h00; vfu_busy = 8'h10; cip = 16'o170456;
    smp();
    check_out("ext.fu_busy", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    vfu_busy = 8'h00;
    smp();
    check_out("ext.fu_free", 1'b1, 1'b0, 8'h10, 8'h60, 8'h10);
    adv();
    vreg_busy = 8'h80; cip = 16'o161735;
    smp();
    check_out("ext.vi_busy", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    vreg_busy = 8'h00;
    smp();
    check_out("ext.vi_free", 1'b1, 1'b0, 8'h80, 8'h28, 8'h08);
    adv();

    // 5: memory read blocked by A-register reservations
    do_reset();
    vl = 7'd8; cip = 16'o177042; cip_vld = 1'b1; a_res_mask = 8'h01;
    smp();
    check_out("t5.a0", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    a_res_mask = 8'h04;
    smp();
    check_out("t5.ak", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    adv();
    a_res_mask = 8'h02;
    smp();
    check_out("t5.go", 1'b1, 1'b0, 8'h00, 8'h10, 8'h80);
    check_fu("t5.go", 3'd7, 4'd9);
    adv();
    a_res_mask = 8'h00; cip = 16'o174013;
    smp();
    check_out("dec.unlisted", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    check_fu("dec.unlisted", 3'd0, 4'd0);
    adv();
    cip = 16'o174011;
    smp();
    check_out("dec.vpop", 1'b1, 1'b0, 8'h01, 8'h02, 8'h40);
    check_fu("dec.vpop", 3'd6, 4'd5);
    adv();
    cip = 16'o020000;
    smp();
    check_out("dec.scalar", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    adv();

    // 6: write to V2 waits for its readers; a read reload on the zero cycle sticks
    do_reset();
    vl = 7'd2; cip = 16'o155321; cip_vld = 1'b1;
    smp();
    check_out("t6.rd1", 1'b1, 1'b0, 8'h08, 8'h06, 8'h04);
    adv();
    cip_vld = 1'b0;
    adv();
    cip = 16'o161425; cip_vld = 1'b1;
    smp();
    check_out("t6.rd2", 1'b1, 1'b0, 8'h10, 8'h24, 8'h08);
    adv();
    cip = 16'o140245;
    wait_issue(20, holds, got);
    chk("t6.got", 32'(got), 32'h1);
    chk("t6.holds", 32'(holds), 32'd2);
    check_out("t6.wr", 1'b1, 1'b0, 8'h04, 8'h20, 8'h01);
    adv();
    cip_vld = 1'b0;
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
